// File: rtl/frac_to_dec_stream.sv
// frac_to_dec_stream: converts an integer digit plus a FRAC_W-bit binary
// fraction (value = frac_in / 2^FRAC_W) into a stream of decimal digits.
// Digit 0 is int_in. Each following digit comes from one multiply-by-10 step.
// Output is a valid/ready stream with digit index, last flag and abort.
//
// Optional feature: define FRAC_TO_DEC_ZERO_STOP_EN to end the stream early
// at the first digit after which the remaining fraction is zero.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, abort      conversion request (IDLE only) / cancel
//   frac_in, int_in   operands, captured when start is accepted
//   digit             current decimal digit
//   digit_valid       digit/digit_idx/digit_last are valid
//   digit_ready       sink accepts the digit
//   digit_last        current digit is the final one
//   digit_idx         0 = integer digit, k = k-th fraction digit
//   busy              high while emitting
//   done              one-cycle pulse after the final digit transfers
module frac_to_dec_stream #(
    parameter int unsigned FRAC_W     = 392,
    parameter int unsigned NUM_DIGITS = 118,
    parameter int unsigned IDX_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FRAC_W-1:0] frac_in,
    input  logic [3:0]        int_in,
    output logic [3:0]        digit,
    output logic              digit_valid,
    input  logic              digit_ready,
    output logic              digit_last,
    output logic [IDX_W-1:0]  digit_idx,
    output logic              busy,
    output logic              done
);

`ifdef FRAC_TO_DEC_ZERO_STOP_EN
    localparam bit ZERO_STOP = 1'b1;
`else
    localparam bit ZERO_STOP = 1'b0;
`endif

    localparam int unsigned PROD_W = FRAC_W + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [FRAC_W-1:0] frac_q;

    // Multiply-by-10 step at full width: (f<<3)+(f<<1) cannot overflow PROD_W.
    logic [PROD_W-1:0] frac_ext_c;
    logic [PROD_W-1:0] prod_c;
    logic [3:0]        next_digit_c;
    logic [FRAC_W-1:0] next_frac_c;
    logic [IDX_W-1:0]  next_idx_c;
    logic              next_last_c;
    logic              first_last_c;

    always_comb begin
        frac_ext_c   = PROD_W'(frac_q);
        prod_c       = (frac_ext_c << 3) + (frac_ext_c << 1);
        next_digit_c = prod_c[PROD_W-1:FRAC_W];
        next_frac_c  = prod_c[FRAC_W-1:0];
        next_idx_c   = digit_idx + IDX_W'(1);
        next_last_c  = (next_idx_c == IDX_W'(NUM_DIGITS)) ||
                       (ZERO_STOP && (next_frac_c == '0));
        first_last_c = (NUM_DIGITS == 0) ||
                       (ZERO_STOP && (frac_in == '0));
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frac_q      <= '0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            digit_last  <= 1'b0;
            digit_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        frac_q      <= frac_in;
                        digit       <= int_in;
                        digit_idx   <= '0;
                        digit_valid <= 1'b1;
                        digit_last  <= first_last_c;
                        busy        <= 1'b1;
                        state       <= EMIT;
                    end
                end
                EMIT: begin
                    // Abort outranks a transfer in the same cycle.
                    if (abort) begin
                        digit_valid <= 1'b0;
                        digit_last  <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (digit_valid && digit_ready) begin
                        if (digit_last) begin
                            digit_valid <= 1'b0;
                            digit_last  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            frac_q     <= next_frac_c;
                            digit      <= next_digit_c;
                            digit_idx  <= next_idx_c;
                            digit_last <= next_last_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    digit_valid <= 1'b0;
                    digit_last  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frac_to_dec_stream.sv
// Testbench for frac_to_dec_stream with FRAC_W=8, NUM_DIGITS=4. Expected
// digit sequences are computed by decimal long multiplication of the
// fraction value (integer arithmetic on frac/256).
module tb_frac_to_dec_stream;

    localparam int unsigned FW = 8;
    localparam int unsigned ND = 4;
    localparam int unsigned IW = $clog2(ND + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [FW-1:0] frac_in;
    logic [3:0]    int_in;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          digit_ready;
    logic          digit_last;
    logic [IW-1:0] digit_idx;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

`ifdef FRAC_TO_DEC_ZERO_STOP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    frac_to_dec_stream #(.FRAC_W(FW), .NUM_DIGITS(ND)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .frac_in(frac_in), .int_in(int_in), .digit(digit),
        .digit_valid(digit_valid), .digit_ready(digit_ready),
        .digit_last(digit_last), .digit_idx(digit_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Decimal expansion of iv + fv/256, limited to ND fraction digits.
    task automatic build_model(input int iv, input int fv);
        int f;
        exp_q = {};
        exp_q.push_back(iv);
        f = fv;
        if (ZS && f == 0) return;
        for (int k = 1; k <= ND; k++) begin
            exp_q.push_back((f * 10) / 256);
            f = (f * 10) % 256;
            if (ZS && f == 0) return;
        end
    endtask

    // ready_mode: 0 = always 1, 1 = pattern 1,0,0 repeating, 2 = random.
    // abort_idx >= 0 aborts when that index is presented.
    task automatic run_stream(input int iv, input int fv, input int ready_mode,
                              input int abort_idx, input bit poke_start,
                              input string name);
        int n, cyc;
        bit r, finished, hold_pending, aborted;
        int h_digit, h_idx;
        build_model(iv, fv);
        @(negedge clk);
        start = 1'b1; frac_in = FW'(fv); int_in = 4'(iv);
        @(posedge clk); #1;
        start = 1'b0; frac_in = ~frac_in;
        n = 0; cyc = 0; finished = 0; hold_pending = 0; aborted = 0;
        h_digit = 0; h_idx = 0;
        while (!finished && !aborted && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check({name, "_first_valid"}, int'(digit_valid), 1);
                check({name, "_busy"}, int'(busy), 1);
            end
            if (hold_pending) begin
                check({name, "_hold_valid"}, int'(digit_valid), 1);
                check({name, "_hold_digit"}, int'(digit), h_digit);
                check({name, "_hold_idx"}, int'(digit_idx), h_idx);
            end
            case (ready_mode)
                0: r = 1'b1;
                1: r = ((cyc - 1) % 3) == 0;
                default: r = 1'($urandom_range(0, 1));
            endcase
            digit_ready = r;
            if (poke_start && cyc == 2) begin
                start = 1'b1; frac_in = 8'h5B;
            end
            if (abort_idx >= 0 && digit_valid && int'(digit_idx) == abort_idx) begin
                abort = 1'b1;
                aborted = 1;
            end else if (digit_valid && r) begin
                if (n < exp_q.size()) begin
                    check({name, "_digit"}, int'(digit), exp_q[n]);
                    check({name, "_idx"}, int'(digit_idx), n);
                    check({name, "_last"}, int'(digit_last),
                          int'(n == exp_q.size() - 1));
                end else begin
                    check({name, "_extra_digit"}, n, exp_q.size() - 1);
                end
                if (digit_last) finished = 1;
                n++;
            end
            hold_pending = digit_valid && !r && !aborted;
            h_digit = int'(digit); h_idx = int'(digit_idx);
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
        end
        if (aborted) begin
            @(negedge clk);
            check({name, "_abort_valid"}, int'(digit_valid), 0);
            check({name, "_abort_busy"}, int'(busy), 0);
            for (int i = 0; i < 3; i++) begin
                check({name, "_abort_no_done"}, int'(done), 0);
                @(negedge clk);
            end
        end else if (finished) begin
            check({name, "_count"}, n, exp_q.size());
            @(negedge clk);
            check({name, "_done"}, int'(done), 1);
            check({name, "_end_valid"}, int'(digit_valid), 0);
            check({name, "_end_busy"}, int'(busy), 0);
            @(negedge clk);
            check({name, "_done_pulse"}, int'(done), 0);
        end else begin
            check({name, "_timeout"}, cyc, -1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        frac_in = '0; int_in = 4'd0; digit_ready = 1'b0;
        #12;
        check("rst_valid", int'(digit_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_digit", int'(digit), 0);
        check("rst_idx", int'(digit_idx), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk); rst_n = 1'b1;

        // 3.5: digits 3,5,0,0,0 (or 3,5 with zero-stop)
        run_stream(3, 8'h80, 0, -1, 1'b0, "half");
        // 26/256 = 0.1015625: digits 0,1,0,1,5
        run_stream(0, 8'h1A, 0, -1, 1'b0, "x1a");
        run_stream(0, 8'h1A, 1, -1, 1'b0, "bp");
        run_stream(7, 8'h1A, 0, 2, 1'b0, "abort");
        run_stream(2, 8'h1A, 0, -1, 1'b0, "restart");
        run_stream(6, 8'h33, 0, -1, 1'b1, "poke");

        // Start is ignored in IDLE while abort is also high.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; frac_in = 8'h44;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", int'(digit_valid), 0);

        // Async reset mid-stream, between clock edges.
        @(negedge clk);
        digit_ready = 1'b1; start = 1'b1; frac_in = 8'h1A; int_in = 4'd9;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("arst_valid", int'(digit_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_idx", int'(digit_idx), 0);
        check("arst_digit", int'(digit), 0);
        check("arst_done", int'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        run_stream(4, 0, 0, -1, 1'b0, "zero");

        for (int t = 0; t < 30; t++)
            run_stream(int'($urandom_range(0, 9)), int'($urandom_range(0, 255)),
                       2, -1, 1'b0, "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
